mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the core fetch path and the load/store path.
//  Grants one requester per transaction and sequences the fixed-latency memory access.
//  Routes the read data back to the requester that was granted.
//  Sits between pc/decoder/execute in the core and the unified memory macro; the core stalls on !gnt.
// PARAMETERS
//  ADDR_W      64  address width (byte address)
//  DATA_W      64  data width; strobe width = DATA_W/8
//  LAT         2   memory read latency in cycles, mem_en to mem_rdata valid; legal range 1..7
//  STARVE_MAX  4   consecutive data grants allowed while if_req waits; legal range 1..15
// PORTS
//  clk         in   1         clock
//  rst         in   1         synchronous active-high reset
//  if_req      in   1         fetch request; held high with if_addr stable until if_gnt
//  if_addr     in   ADDR_W    fetch address
//  if_gnt      out  1         fetch accepted this cycle
//  if_rvalid   out  1         one-cycle pulse, if_rdata valid
//  if_rdata    out  DATA_W    fetch read data
//  d_req       in   1         load/store request; held with d_* stable until d_gnt
//  d_we        in   1         1 = store, 0 = load
//  d_addr      in   ADDR_W    data address
//  d_wdata     in   DATA_W    store data
//  d_wstrb     in   DATA_W/8  store byte enables
//  d_gnt       out  1         data request accepted this cycle
//  d_rvalid    out  1         one-cycle pulse: load data valid, or store complete
//  d_rdata     out  DATA_W    load data; 0 on store completion
//  mem_en      out  1         memory access strobe
//  mem_we      out  1         memory write enable
//  mem_addr    out  ADDR_W    memory address
//  mem_wdata   out  DATA_W    memory write data
//  mem_wstrb   out  DATA_W/8  memory byte enables
//  mem_rdata   in   DATA_W    memory read data, valid LAT cycles after mem_en
//  busy        out  1         transaction outstanding (state != IDLE)
//  if_stall_cnt out 32        cycles with if_req && !if_gnt
//  d_stall_cnt  out 32        cycles with d_req && !d_gnt
// BEHAVIOUR
//  FSM states: IDLE, WAIT. Exactly one transaction outstanding at a time.
//  IDLE with any req: grant one requester combinationally in that cycle.
//   - Grant cycle: gnt=1, mem_en=1, mem_* = granted requester's inputs; mem_we=d_we for data grants, 0 for fetch.
//   - Register owner (IF/D) and op (rd/wr); load cnt=LAT-1; go to WAIT.
//  IDLE, no req: stay IDLE; all strobes low; mem_* address/data outputs 0.
//  WAIT: no grants; mem_en=0. Decrement cnt each cycle.
//   - cnt==0: pulse owner's rvalid; rdata=mem_rdata (load/fetch) or 0 (store); go to IDLE.
//   - A transaction granted at cycle T returns rvalid at cycle T+LAT.
//   - Earliest next grant is cycle T+LAT; the rvalid cycle is in IDLE, so back-to-back grant is allowed.
//  Priority: data beats fetch by default.
//   - starve counter (4 bits) increments on each d_gnt while if_req=1; clears on if_gnt or when if_req=0.
//   - When starve==STARVE_MAX and if_req=1, fetch wins the next IDLE grant.
//  Non-owner rvalid stays 0; non-owner rdata holds its last value.
//  Reset (any state, incl. mid-WAIT): state=IDLE, owner/cnt/starve=0, all gnt/rvalid/mem_en/mem_we/busy=0.
//   - if_rdata/d_rdata=0; stall counters=0. No rvalid is issued for an abandoned transaction.
//  Stall counters saturate at 32'hFFFF_FFFF (no wrap).
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: if_stall_cnt/d_stall_cnt count as above.
//  MEM_ARB_PERF_EN undefined: both ports tied to 32'h0; no counter flops synthesised.
//  Arbitration and timing are identical either way.
// TESTING (LAT=2, STARVE_MAX=4, MEM_ARB_PERF_EN defined)
//  1. if_req=1, if_addr=0x100, mem holds 0x13 at 0x100 -> if_gnt at T0; if_rvalid=1, if_rdata=0x13 at T2; busy high T1 only.
//  2. if_req and d_req (load 0x200) both rise at T0 -> d_gnt at T0, if_gnt at T2; d_stall_cnt=0, if_stall_cnt=2.
//  3. d_req=1 continuously, if_req=1 -> d_gnt at T0,T2,T4,T6; if_gnt at T8 (STARVE_MAX hit); then d_gnt at T10.
//  4. Store d_addr=0x40, d_wdata=0xAA, d_wstrb=0x01 -> mem_we=1, mem_wstrb=0x01 at T0; d_rvalid=1, d_rdata=0 at T2.
//  5. rst=1 at T1 after fetch grant at T0 -> no if_rvalid at T2; busy=0, counters=0 at T2; new grant allowed at T2.
//  6. Same stimulus as scenario 2, MEM_ARB_PERF_EN undefined -> identical gnt/rvalid timing; both stall counts read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch path (if_*) and the
//   load/store path (d_*). One transaction is outstanding at a time. The
//   grant, and the memory strobe for it, are issued combinationally in an idle
//   cycle. The response is returned LAT cycles after the grant.
//
//   Parameters: ADDR_W, DATA_W (strobe width DATA_W/8), LAT (1..7), STARVE_MAX (1..15)
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     if_req/if_addr               fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata    fetch grant, response pulse, response data
//     d_req/d_we/d_addr/d_wdata/d_wstrb   load/store request (held until d_gnt)
//     d_gnt/d_rvalid/d_rdata       data grant, response pulse, load data (0 for stores)
//     mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb/mem_rdata   memory macro port
//     busy                         a transaction is waiting for its read latency
//     if_stall_cnt/d_stall_cnt     saturating counts of cycles with req && !gnt
//
//   Optional feature macro: MEM_ARB_PERF_EN. When it is defined the stall
//   counters are built. When it is undefined both counter ports read 32'h0.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic [31:0]           if_stall_cnt,
   output logic [31:0]           d_stall_cnt
);

   localparam int SW = DATA_W/8;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   // cnt holds the number of WAIT cycles still to run. The response cycle
   // itself is spent in IDLE, so the next grant can overlap it.
   localparam logic [2:0] CNT_LOAD   = 3'(LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [0:0]        state;
   logic              owner_d;     // 1: data path owns the transaction, 0: fetch
   logic              op_wr;
   logic [2:0]        cnt;
   logic [3:0]        starve;
   logic              rsp_pend;
   logic [DATA_W-1:0] if_hold;
   logic [DATA_W-1:0] d_hold;
   logic              can_grant;
   logic              fetch_win;

   // Arbitration: data wins unless fetch has been passed over STARVE_MAX times.
   always_comb begin
      can_grant = (state == IDLE) && !rst;
      fetch_win = if_req && (!d_req || (starve >= STARVE_LIM));
      if_gnt    = can_grant && fetch_win;
      d_gnt     = can_grant && d_req && !fetch_win;
   end

   // Memory port: pass the granted requester straight through. Otherwise drive 0.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_wstrb = {SW{1'b0}};
      if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wstrb = d_wstrb;
      end else if (if_gnt) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end else begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
      end
   end

   // Response routing: memory data is valid during the response cycle only,
   // so it passes through then. Each port holds its last value otherwise.
   always_comb begin
      if_rvalid = rsp_pend && !owner_d && !rst;
      d_rvalid  = rsp_pend && owner_d && !rst;
      if (if_rvalid) begin
         if_rdata = mem_rdata;
      end else begin
         if_rdata = if_hold;
      end
      if (d_rvalid) begin
         d_rdata = op_wr ? {DATA_W{1'b0}} : mem_rdata;
      end else begin
         d_rdata = d_hold;
      end
   end

   assign busy = (state == WAIT);

   // Transaction sequencer: grant -> WAIT for LAT-1 cycles -> response cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner_d  <= 1'b0;
         op_wr    <= 1'b0;
         cnt      <= 3'd0;
         rsp_pend <= 1'b0;
      end else begin
         rsp_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (if_gnt || d_gnt) begin
                  owner_d <= d_gnt;
                  op_wr   <= d_gnt && d_we;
                  cnt     <= CNT_LOAD;
                  if (LAT == 1) begin
                     rsp_pend <= 1'b1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt <= 3'd1) begin
                  state    <= IDLE;
                  cnt      <= 3'd0;
                  rsp_pend <= 1'b1;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Last-delivered read data for each requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_hold <= {DATA_W{1'b0}};
         d_hold  <= {DATA_W{1'b0}};
      end else begin
         if (if_rvalid) if_hold <= if_rdata;
         if (d_rvalid)  d_hold  <= d_rdata;
      end
   end

   // Starvation counter: counts data grants while fetch is waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= 4'd0;
      end else if (!if_req || if_gnt) begin
         starve <= 4'd0;
      end else if (d_gnt && (starve != 4'hF)) begin
         starve <= starve + 4'd1;
      end
   end

`ifdef MEM_ARB_PERF_EN
   // Saturating stall counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_stall_cnt <= 32'd0;
         d_stall_cnt  <= 32'd0;
      end else begin
         if (if_req && !if_gnt && (if_stall_cnt != 32'hFFFF_FFFF)) if_stall_cnt <= if_stall_cnt + 32'd1;
         if (d_req && !d_gnt && (d_stall_cnt != 32'hFFFF_FFFF))    d_stall_cnt  <= d_stall_cnt + 32'd1;
      end
   end
`else
   assign if_stall_cnt = 32'h0;
   assign d_stall_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (LAT=2, STARVE_MAX=4). It contains a word
// memory with a LAT-deep read pipeline and directed scenarios. It also runs a
// randomized run checked each cycle against a timeline reference model.
module tb_mem_port_arbiter;
   localparam int AW = 64, DW = 64, LAT = 2, SM = 4;
`ifdef MEM_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] if_addr = 64'd0, d_addr = 64'd0;
   logic [DW-1:0] d_wdata = 64'd0;
   logic [7:0] d_wstrb = 8'd0;
   logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0] mem_wstrb;
   logic [31:0] if_stall_cnt, d_stall_cnt;
   int total = 0, bad = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .busy(busy), .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt));

   always #5 clk = ~clk;

   // Memory: 512 words. Unwritten words return a fixed pattern.
   logic [63:0] mem [0:511];
   logic        written [0:511];
   logic [63:0] pipe [0:LAT-1];

   function automatic logic [63:0] init_pat(input logic [8:0] i);
      if (i == 9'd32) return 64'h13;
      return {23'h5A5A5A, i, 23'h0F0F0F, i};
   endfunction

   function automatic logic [63:0] rd_word(input logic [8:0] i);
      if (written[i] === 1'b1) return mem[i];
      return init_pat(i);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] st);
      logic [63:0] r = old;
      for (int b = 0; b < 8; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [63:0] rand_addr();
      logic [8:0] w = 9'($urandom_range(0, 511));
      return {52'h0, w, 3'b000};
   endfunction

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[mem_addr[11:3]]     <= merge(rd_word(mem_addr[11:3]), mem_wdata, mem_wstrb);
         written[mem_addr[11:3]] <= 1'b1;
      end
      pipe[0] <= (mem_en && !mem_we) ? rd_word(mem_addr[11:3]) : {$urandom, $urandom};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[LAT-1];

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0) begin bad++; $display("FAIL reset_strobes: got %b want 000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}); end
      total++; if (mem_addr !== 64'd0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      total++; if ({if_rdata, d_rdata} !== 128'd0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0", if_rdata, d_rdata); end
      total++; if ({if_stall_cnt, d_stall_cnt} !== 64'd0) begin bad++; $display("FAIL reset_counters: got %0d/%0d want 0", if_stall_cnt, d_stall_cnt); end
   endtask

   task automatic test_fetch();
      do_reset();
      if_req = 1'b1; if_addr = 64'h100; #1;
      total++; if ({if_gnt, d_gnt, mem_en, mem_we, busy} !== 5'b10100) begin bad++; $display("FAIL fetch_grant: got %b want 10100", {if_gnt, d_gnt, mem_en, mem_we, busy}); end
      total++; if (mem_addr !== 64'h100) begin bad++; $display("FAIL fetch_mem_addr: got %h want 100", mem_addr); end
      @(negedge clk); if_req = 1'b0; #1;
      total++; if ({busy, if_rvalid, mem_en} !== 3'b100) begin bad++; $display("FAIL fetch_t1: got %b want 100", {busy, if_rvalid, mem_en}); end
      @(negedge clk); #1;
      total++; if ({if_rvalid, busy} !== 2'b10) begin bad++; $display("FAIL fetch_t2_valid: got %b want 10", {if_rvalid, busy}); end
      total++; if (if_rdata !== 64'h13) begin bad++; $display("FAIL fetch_t2_data: got %h want 13", if_rdata); end
      @(negedge clk); #1;
      total++; if (if_rvalid !== 1'b0 || if_rdata !== 64'h13) begin bad++; $display("FAIL fetch_hold: got %b/%h want 0/13", if_rvalid, if_rdata); end
   endtask

   task automatic test_priority();
      do_reset();
      if_req = 1'b1; if_addr = 64'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200; #1;
      total++; if ({d_gnt, if_gnt} !== 2'b10 || mem_addr !== 64'h200) begin bad++; $display("FAIL prio_t0: got %b addr %h want 10 addr 200", {d_gnt, if_gnt}, mem_addr); end
      @(negedge clk); d_req = 1'b0; #1;
      total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL prio_t1_gnt: got %b want 0", if_gnt); end
      @(negedge clk); #1;
      total++; if ({if_gnt, d_rvalid} !== 2'b11) begin bad++; $display("FAIL prio_t2: got %b want 11", {if_gnt, d_rvalid}); end
      total++; if (d_rdata !== init_pat(9'd64)) begin bad++; $display("FAIL prio_load_data: got %h want %h", d_rdata, init_pat(9'd64)); end
      total++; if (if_stall_cnt !== (PERF ? 32'd2 : 32'd0) || d_stall_cnt !== 32'd0) begin bad++; $display("FAIL prio_stall: got %0d/%0d want %0d/0", if_stall_cnt, d_stall_cnt, PERF ? 2 : 0); end
      @(negedge clk); if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_starve();
      do_reset();
      if_req = 1'b1; if_addr = 64'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h208;
      for (int c = 0; c <= 10; c++) begin
         bit ed, ei;
         #1;
         ed = (c == 0 || c == 2 || c == 4 || c == 6 || c == 10);
         ei = (c == 8);
         total++; if ({d_gnt, if_gnt} !== {ed, ei}) begin bad++; $display("FAIL starve_c%0d: got %b want %b", c, {d_gnt, if_gnt}, {ed, ei}); end
         @(negedge clk);
      end
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_store();
      logic [63:0] e;
      do_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'hAA; d_wstrb = 8'h01; #1;
      total++; if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_wstrb !== 8'h01 || mem_wdata !== 64'hAA || mem_addr !== 64'h40) begin bad++; $display("FAIL store_t0: got %b strb %h data %h addr %h", {d_gnt, mem_en, mem_we}, mem_wstrb, mem_wdata, mem_addr); end
      @(negedge clk); d_req = 1'b0; @(negedge clk); #1;
      total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'd0) begin bad++; $display("FAIL store_done: got %b/%h want 1/0", d_rvalid, d_rdata); end
      d_req = 1'b1; d_we = 1'b0; #1;
      total++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL store_b2b_gnt: got %b/%b want 1/0", d_gnt, mem_we); end
      @(negedge clk); d_req = 1'b0; @(negedge clk); #1;
      e = init_pat(9'd8); e[7:0] = 8'hAA;
      total++; if (d_rvalid !== 1'b1 || d_rdata !== e) begin bad++; $display("FAIL store_readback: got %b/%h want 1/%h", d_rvalid, d_rdata, e); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      if_req = 1'b1; if_addr = 64'h100; #1;
      total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt: got %b want 1", if_gnt); end
      @(negedge clk); if_req = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0; if_req = 1'b1; #1;
      total++; if ({if_rvalid, busy, if_gnt} !== 3'b001) begin bad++; $display("FAIL rstmid_t2: got %b want 001", {if_rvalid, busy, if_gnt}); end
      total++; if ({if_stall_cnt, d_stall_cnt} !== 64'd0 || if_rdata !== 64'd0) begin bad++; $display("FAIL rstmid_clear: got %0d/%0d/%h want 0", if_stall_cnt, d_stall_cnt, if_rdata); end
      @(negedge clk); if_req = 1'b0; @(negedge clk); #1;
      total++; if (if_rvalid !== 1'b1 || if_rdata !== 64'h13) begin bad++; $display("FAIL rstmid_regrant: got %b/%h want 1/13", if_rvalid, if_rdata); end
   endtask

   // Reference timeline: a grant in cycle n makes the port free again in cycle
   // n+LAT, and the response appears in that same cycle.
   task automatic test_random(input int ncyc);
      int free_at = 0, last_g = -10, resp_at = -1, starve = 0;
      bit resp_d = 1'b0, resp_st = 1'b0, ig_prev = 1'b0, dg_prev = 1'b0;
      logic [63:0] resp_data = 64'd0, ih = 64'd0, dh = 64'd0;
      logic [31:0] isc = 32'd0, dsc = 32'd0;
      do_reset();
      for (int n = 0; n < ncyc; n++) begin
         bit can, fwin, e_ig, e_dg, e_busy, e_irv, e_drv, e_we;
         logic [63:0] e_ird, e_drd, e_addr, e_wd;
         logic [7:0] e_st;
         if (ig_prev) if_req = 1'b0;
         if (dg_prev) d_req = 1'b0;
         if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = rand_addr(); end
         if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
            d_wdata = {$urandom, $urandom}; d_wstrb = 8'($urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         #1;
         can    = (n >= free_at) && !rst;
         fwin   = if_req && (!d_req || starve >= SM);
         e_ig   = can && fwin;
         e_dg   = can && d_req && !fwin;
         e_busy = (n > last_g) && (n < free_at);
         e_irv  = (n == resp_at) && !resp_d && !rst;
         e_drv  = (n == resp_at) && resp_d && !rst;
         e_ird  = e_irv ? resp_data : ih;
         e_drd  = e_drv ? (resp_st ? 64'd0 : resp_data) : dh;
         e_we   = e_dg && d_we;
         e_addr = e_dg ? d_addr : (e_ig ? if_addr : 64'd0);
         e_wd   = e_dg ? d_wdata : 64'd0;
         e_st   = e_dg ? d_wstrb : 8'd0;
         total++; if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin bad++; $display("FAIL rnd_gnt n=%0d: got %b want %b", n, {if_gnt, d_gnt}, {e_ig, e_dg}); end
         total++; if ({mem_en, mem_we} !== {e_ig | e_dg, e_we}) begin bad++; $display("FAIL rnd_mem_en n=%0d: got %b want %b", n, {mem_en, mem_we}, {e_ig | e_dg, e_we}); end
         total++; if (mem_addr !== e_addr || mem_wdata !== e_wd || mem_wstrb !== e_st) begin bad++; $display("FAIL rnd_mem_bus n=%0d: got %h/%h/%h want %h/%h/%h", n, mem_addr, mem_wdata, mem_wstrb, e_addr, e_wd, e_st); end
         total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy n=%0d: got %b want %b", n, busy, e_busy); end
         total++; if ({if_rvalid, d_rvalid} !== {e_irv, e_drv}) begin bad++; $display("FAIL rnd_rvalid n=%0d: got %b want %b", n, {if_rvalid, d_rvalid}, {e_irv, e_drv}); end
         total++; if (if_rdata !== e_ird || d_rdata !== e_drd) begin bad++; $display("FAIL rnd_rdata n=%0d: got %h/%h want %h/%h", n, if_rdata, d_rdata, e_ird, e_drd); end
         total++; if (if_stall_cnt !== (PERF ? isc : 32'd0) || d_stall_cnt !== (PERF ? dsc : 32'd0)) begin bad++; $display("FAIL rnd_stall n=%0d: got %0d/%0d want %0d/%0d", n, if_stall_cnt, d_stall_cnt, PERF ? isc : 32'd0, PERF ? dsc : 32'd0); end
         ih = e_ird; dh = e_drd;
         if (if_req && !e_ig) isc = isc + 32'd1;
         if (d_req && !e_dg)  dsc = dsc + 32'd1;
         if (!if_req || e_ig) starve = 0;
         else if (e_dg) starve = starve + 1;
         if (e_ig || e_dg) begin
            last_g = n; free_at = n + LAT; resp_at = n + LAT;
            resp_d = e_dg; resp_st = e_we; resp_data = rd_word(e_addr[11:3]);
         end
         if (rst) begin
            free_at = n + 1; resp_at = -1; starve = 0;
            ih = 64'd0; dh = 64'd0; isc = 32'd0; dsc = 32'd0;
         end
         ig_prev = e_ig; dg_prev = e_dg;
         @(negedge clk);
      end
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_starve();
      test_store();
      test_reset_mid();
      test_random(3000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
